// File: rtl/gemm2x2_seq_ctrl.sv
// gemm2x2_seq_ctrl
//   Sequencer for a 2x2 GEMM tile computed one K-slice at a time. For each slice it
//   fetches the A column / B row operands, issues them together with the running
//   partial sums to an external 2x2 MAC array, waits for the MAC result and stores
//   it as the new partials. After k_len slices the partials become the result tile.
//   No arithmetic happens here; the MAC array does all multiply-accumulate work.
//
// Ports
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_start, i_k_len            job request and slice count (sampled only in idle)
//   o_busy, o_done              not-idle flag, one-cycle completion pulse
//   o_op_req, o_op_idx          operand fetch request and slice index
//   i_op_vld, i_op_a*/i_op_b*   fetch response and slice operands
//   o_mac_in_valid              issue strobe to the MAC array
//   o_mac_a*/o_mac_b*           registered slice operands
//   o_mac_acc*                  running partial sums fed to the MAC array
//   i_mac_out_valid, i_mac_y*   MAC result strobe and values
//   o_res*                      final C tile, held until the next accepted start
//   o_err                       sticky: MAC result arrived outside the wait state
module gemm2x2_seq_ctrl #(
    parameter int unsigned KW = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [KW-1:0]        i_k_len,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_op_req,
    output logic [KW-1:0]        o_op_idx,
    input  logic                 i_op_vld,
    input  logic signed [7:0]    i_op_a0,
    input  logic signed [7:0]    i_op_a1,
    input  logic signed [7:0]    i_op_b0,
    input  logic signed [7:0]    i_op_b1,
    output logic                 o_mac_in_valid,
    output logic signed [7:0]    o_mac_a0,
    output logic signed [7:0]    o_mac_a1,
    output logic signed [7:0]    o_mac_b0,
    output logic signed [7:0]    o_mac_b1,
    output logic signed [31:0]   o_mac_acc00,
    output logic signed [31:0]   o_mac_acc01,
    output logic signed [31:0]   o_mac_acc10,
    output logic signed [31:0]   o_mac_acc11,
    input  logic                 i_mac_out_valid,
    input  logic signed [31:0]   i_mac_y00,
    input  logic signed [31:0]   i_mac_y01,
    input  logic signed [31:0]   i_mac_y10,
    input  logic signed [31:0]   i_mac_y11,
    output logic signed [31:0]   o_res00,
    output logic signed [31:0]   o_res01,
    output logic signed [31:0]   o_res10,
    output logic signed [31:0]   o_res11,
    output logic                 o_err
);

    typedef enum logic [2:0] {StIdle, StFetch, StIssue, StWait, StDone} state_t;

    state_t             r_state;
    logic [KW-1:0]      r_k_len;
    logic [KW-1:0]      r_k_cnt;
    logic               r_busy;
    logic               r_done;
    logic               r_op_req;
    logic               r_mac_in_valid;
    logic               r_err;
    logic signed [7:0]  r_a0, r_a1, r_b0, r_b1;
    logic signed [31:0] r_acc00, r_acc01, r_acc10, r_acc11;
    logic signed [31:0] r_res00, r_res01, r_res10, r_res11;
    logic [KW-1:0]      w_k_next;

    // Compared against k_len before storing, so k_len = 2^KW-1 finishes without wrap.
    assign w_k_next = r_k_cnt + KW'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= StIdle;
            r_k_len        <= '0;
            r_k_cnt        <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_op_req       <= 1'b0;
            r_mac_in_valid <= 1'b0;
            r_err          <= 1'b0;
            r_a0           <= '0;
            r_a1           <= '0;
            r_b0           <= '0;
            r_b1           <= '0;
            r_acc00        <= '0;
            r_acc01        <= '0;
            r_acc10        <= '0;
            r_acc11        <= '0;
            r_res00        <= '0;
            r_res01        <= '0;
            r_res10        <= '0;
            r_res11        <= '0;
        end else begin
            // Stray MAC result: flag only, data is dropped. An accepted start below
            // overrides this because its clear is assigned later.
            if (i_mac_out_valid && (r_state != StWait)) begin
                r_err <= 1'b1;
            end

            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_k_len <= i_k_len;
                        r_k_cnt <= '0;
                        r_acc00 <= '0;
                        r_acc01 <= '0;
                        r_acc10 <= '0;
                        r_acc11 <= '0;
                        r_res00 <= '0;
                        r_res01 <= '0;
                        r_res10 <= '0;
                        r_res11 <= '0;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                        if (i_k_len == '0) begin
                            r_done  <= 1'b1;
                            r_state <= StDone;
                        end else begin
                            r_op_req <= 1'b1;
                            r_state  <= StFetch;
                        end
                    end
                end
                StFetch: begin
                    if (i_op_vld) begin
                        r_a0           <= i_op_a0;
                        r_a1           <= i_op_a1;
                        r_b0           <= i_op_b0;
                        r_b1           <= i_op_b1;
                        r_op_req       <= 1'b0;
                        r_mac_in_valid <= 1'b1;
                        r_state        <= StIssue;
                    end
                end
                StIssue: begin
                    r_mac_in_valid <= 1'b0;
                    r_state        <= StWait;
                end
                StWait: begin
                    if (i_mac_out_valid) begin
                        r_acc00 <= i_mac_y00;
                        r_acc01 <= i_mac_y01;
                        r_acc10 <= i_mac_y10;
                        r_acc11 <= i_mac_y11;
                        r_k_cnt <= w_k_next;
                        if (w_k_next == r_k_len) begin
                            // Publish results on entry to done so they are final
                            // during the done pulse.
                            r_res00 <= i_mac_y00;
                            r_res01 <= i_mac_y01;
                            r_res10 <= i_mac_y10;
                            r_res11 <= i_mac_y11;
                            r_done  <= 1'b1;
                            r_state <= StDone;
                        end else begin
                            r_op_req <= 1'b1;
                            r_state  <= StFetch;
                        end
                    end
                end
                StDone: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_done         <= 1'b0;
                    r_busy         <= 1'b0;
                    r_op_req       <= 1'b0;
                    r_mac_in_valid <= 1'b0;
                    r_state        <= StIdle;
                end
            endcase
        end
    end

    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_op_req       = r_op_req;
    assign o_op_idx       = r_k_cnt;
    assign o_mac_in_valid = r_mac_in_valid;
    assign o_mac_a0       = r_a0;
    assign o_mac_a1       = r_a1;
    assign o_mac_b0       = r_b0;
    assign o_mac_b1       = r_b1;
    assign o_mac_acc00    = r_acc00;
    assign o_mac_acc01    = r_acc01;
    assign o_mac_acc10    = r_acc10;
    assign o_mac_acc11    = r_acc11;
    assign o_res00        = r_res00;
    assign o_res01        = r_res01;
    assign o_res10        = r_res10;
    assign o_res11        = r_res11;
    assign o_err          = r_err;

endmodule

// File: tb/tb_gemm2x2_seq_ctrl.sv
// tb_gemm2x2_seq_ctrl
//   Self-checking bench: directed vector table, randomized jobs against a matrix-product
//   reference, and hand-written reset sequences. The bench also plays the operand source
//   and a variable-latency MAC array.
module tb_gemm2x2_seq_ctrl;

    localparam int KW = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [KW-1:0]     k_len = '0;
    logic              busy, done, op_req, mac_in_valid, err;
    logic [KW-1:0]     op_idx;
    logic              op_vld = 1'b0;
    logic signed [7:0] op_a0 = '0, op_a1 = '0, op_b0 = '0, op_b1 = '0;
    logic signed [7:0] mac_a0, mac_a1, mac_b0, mac_b1;
    logic signed [31:0] mac_acc00, mac_acc01, mac_acc10, mac_acc11;
    logic              mac_out_valid = 1'b0;
    logic signed [31:0] mac_y00 = '0, mac_y01 = '0, mac_y10 = '0, mac_y11 = '0;
    logic signed [31:0] res00, res01, res10, res11;

    gemm2x2_seq_ctrl #(.KW(KW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_k_len(k_len),
        .o_busy(busy), .o_done(done), .o_op_req(op_req), .o_op_idx(op_idx),
        .i_op_vld(op_vld), .i_op_a0(op_a0), .i_op_a1(op_a1), .i_op_b0(op_b0),
        .i_op_b1(op_b1), .o_mac_in_valid(mac_in_valid), .o_mac_a0(mac_a0),
        .o_mac_a1(mac_a1), .o_mac_b0(mac_b0), .o_mac_b1(mac_b1),
        .o_mac_acc00(mac_acc00), .o_mac_acc01(mac_acc01), .o_mac_acc10(mac_acc10),
        .o_mac_acc11(mac_acc11), .i_mac_out_valid(mac_out_valid), .i_mac_y00(mac_y00),
        .i_mac_y01(mac_y01), .i_mac_y10(mac_y10), .i_mac_y11(mac_y11),
        .o_res00(res00), .o_res01(res01), .o_res10(res10), .o_res11(res11), .o_err(err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Operand memory: A[0][k]=m_a0[k], A[1][k]=m_a1[k], B[k][0]=m_b0[k], B[k][1]=m_b1[k].
    logic signed [7:0] m_a0 [256];
    logic signed [7:0] m_a1 [256];
    logic signed [7:0] m_b0 [256];
    logic signed [7:0] m_b1 [256];

    typedef struct {
        string name;
        int    k;
        int    a0 [2];
        int    a1 [2];
        int    b0 [2];
        int    b1 [2];
        int    dly;
        int    lat;
        bit    extra;
        int    e00, e01, e10, e11;
        int    cyc;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: C[i][j] summed over the first k slices.
    function automatic int ref_c(input int i, input int j, input int k);
        int s, a, b;
        s = 0;
        for (int n = 0; n < k; n++) begin
            a = (i == 0) ? int'(m_a0[n]) : int'(m_a1[n]);
            b = (j == 0) ? int'(m_b0[n]) : int'(m_b1[n]);
            s += a * b;
        end
        return s;
    endfunction

    function automatic vec_t mk(input string nm, input int k,
                                input int a00, input int a01, input int a10, input int a11,
                                input int b00, input int b01, input int b10, input int b11,
                                input int dly, input int lat, input bit ex,
                                input int e00, input int e01, input int e10, input int e11,
                                input int cyc);
        vec_t v;
        v.name = nm;  v.k = k;
        v.a0[0] = a00; v.a0[1] = a01; v.a1[0] = a10; v.a1[1] = a11;
        // b0 holds column 0 of B, b1 column 1, indexed by slice.
        v.b0[0] = b00; v.b1[0] = b01; v.b0[1] = b10; v.b1[1] = b11;
        v.dly = dly; v.lat = lat; v.extra = ex;
        v.e00 = e00; v.e01 = e01; v.e10 = e10; v.e11 = e11; v.cyc = cyc;
        return v;
    endfunction

    task automatic load_vec(input vec_t v);
        for (int n = 0; n < 2; n++) begin
            m_a0[n] = 8'(v.a0[n]);
            m_a1[n] = 8'(v.a1[n]);
            m_b0[n] = 8'(v.b0[n]);
            m_b1[n] = 8'(v.b1[n]);
        end
    endtask

    // Runs one job. Start cycle is cycle 1; exp_cyc is the cycle in which done is seen.
    task automatic run_job(input string nm, input int k, input int dly, input int lat,
                           input bit extra, input int e00, input int e01, input int e10,
                           input int e11, input int exp_cyc);
        int cyc, stall, fetched, issued, cnt, done_cnt, done_cyc, req_cyc, bound, sl;
        int idx_bad, opnd_bad, acc_bad;
        int y00, y01, y10, y11;
        bit pend;
        stall = 0; fetched = 0; issued = 0; cnt = 0; done_cnt = 0; done_cyc = -1;
        req_cyc = 0; idx_bad = 0; opnd_bad = 0; acc_bad = 0; pend = 1'b0;
        y00 = 0; y01 = 0; y10 = 0; y11 = 0;
        bound = exp_cyc + 40;
        @(posedge clk); #1;
        start = 1'b1;
        k_len = KW'(k);
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 2;
        check({nm, ":err_clr"}, int'(err), 0);
        check({nm, ":busy"}, int'(busy), 1);
        while (cyc <= bound && !(done_cnt > 0 && cyc > done_cyc + 8)) begin
            op_vld = 1'b0;
            mac_out_valid = 1'b0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    pend = 1'b0;
                    mac_out_valid = 1'b1;
                    mac_y00 = y00; mac_y01 = y01; mac_y10 = y10; mac_y11 = y11;
                end
            end
            if (op_req) begin
                req_cyc++;
                if (int'(op_idx) != fetched) idx_bad++;
                if (stall == dly) begin
                    if (fetched < 256) begin
                        op_vld = 1'b1;
                        op_a0 = m_a0[fetched]; op_a1 = m_a1[fetched];
                        op_b0 = m_b0[fetched]; op_b1 = m_b1[fetched];
                    end
                    fetched++;
                    stall = 0;
                end else begin
                    stall++;
                end
            end
            if (mac_in_valid) begin
                sl = issued;
                issued++;
                if (sl < 256) begin
                    if (mac_a0 != m_a0[sl] || mac_a1 != m_a1[sl] ||
                        mac_b0 != m_b0[sl] || mac_b1 != m_b1[sl]) opnd_bad++;
                    if (int'(mac_acc00) != ref_c(0, 0, sl) || int'(mac_acc01) != ref_c(0, 1, sl) ||
                        int'(mac_acc10) != ref_c(1, 0, sl) || int'(mac_acc11) != ref_c(1, 1, sl))
                        acc_bad++;
                    y00 = int'(mac_acc00) + int'(m_a0[sl]) * int'(m_b0[sl]);
                    y01 = int'(mac_acc01) + int'(m_a0[sl]) * int'(m_b1[sl]);
                    y10 = int'(mac_acc10) + int'(m_a1[sl]) * int'(m_b0[sl]);
                    y11 = int'(mac_acc11) + int'(m_a1[sl]) * int'(m_b1[sl]);
                end
                pend = 1'b1;
                cnt = lat;
            end
            if (extra && cyc == 4) begin
                start = 1'b1;
                k_len = KW'(k + 3);
            end else begin
                start = 1'b0;
            end
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_cyc = cyc;
                    check({nm, ":res00"}, int'(res00), e00);
                    check({nm, ":res01"}, int'(res01), e01);
                    check({nm, ":res10"}, int'(res10), e10);
                    check({nm, ":res11"}, int'(res11), e11);
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        op_vld = 1'b0;
        mac_out_valid = 1'b0;
        start = 1'b0;
        check({nm, ":done_cnt"}, done_cnt, 1);
        check({nm, ":latency"}, done_cyc, exp_cyc);
        check({nm, ":fetch_cycles"}, req_cyc, k * (dly + 1));
        check({nm, ":issues"}, issued, k);
        check({nm, ":op_idx_bad"}, idx_bad, 0);
        check({nm, ":operand_bad"}, opnd_bad, 0);
        check({nm, ":acc_bad"}, acc_bad, 0);
        check({nm, ":idle_busy"}, int'(busy), 0);
        check({nm, ":err"}, int'(err), 0);
        check({nm, ":res_held"}, int'(res11), e11);
    endtask

    initial begin
        int k, dly, lat, guard, done_seen;

        vecs[0] = mk("k2", 2, 1, 2, 3, 4, 5, 6, 7, 8, 0, 1, 1'b0, 19, 22, 43, 50, 8);
        vecs[1] = mk("k0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1'b0, 0, 0, 0, 0, 2);
        vecs[2] = mk("k2_stall", 2, 1, 2, 3, 4, 5, 6, 7, 8, 3, 4, 1'b0, 19, 22, 43, 50, 20);
        vecs[3] = mk("k2_restart", 2, 1, 2, 3, 4, 5, 6, 7, 8, 0, 1, 1'b1, 19, 22, 43, 50, 8);
        vecs[4] = mk("k1_extreme", 1, -128, 0, 127, 0, -128, -1, 0, 0, 1, 2, 1'b0,
                     16384, 128, -16256, -127, 7);

        // Reset state, checked while reset is held.
        #12;
        check("rst:busy", int'(busy), 0);
        check("rst:done", int'(done), 0);
        check("rst:op_req", int'(op_req), 0);
        check("rst:op_idx", int'(op_idx), 0);
        check("rst:mac_in_valid", int'(mac_in_valid), 0);
        check("rst:err", int'(err), 0);
        check("rst:mac_acc00", int'(mac_acc00), 0);
        check("rst:res00", int'(res00), 0);
        #3 rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            load_vec(vecs[i]);
            run_job(vecs[i].name, vecs[i].k, vecs[i].dly, vecs[i].lat, vecs[i].extra,
                    vecs[i].e00, vecs[i].e01, vecs[i].e10, vecs[i].e11, vecs[i].cyc);
        end

        // Randomized jobs plus the full-range k_len.
        for (int r = 0; r < 9; r++) begin
            k   = (r == 8) ? 255 : int'($urandom_range(1, 6));
            dly = (r == 8) ? 0 : int'($urandom_range(0, 2));
            lat = (r == 8) ? 1 : int'($urandom_range(1, 3));
            for (int n = 0; n < k; n++) begin
                m_a0[n] = 8'($urandom);
                m_a1[n] = 8'($urandom);
                m_b0[n] = 8'($urandom);
                m_b1[n] = 8'($urandom);
            end
            run_job($sformatf("rnd%0d", r), k, dly, lat, 1'b0,
                    ref_c(0, 0, k), ref_c(0, 1, k), ref_c(1, 0, k), ref_c(1, 1, k),
                    2 + k * (2 + lat) + k * dly);
        end

        // Reset during the wait of slice 0, then a stray MAC result.
        load_vec(vecs[0]);
        @(posedge clk); #1;
        start = 1'b1;
        k_len = KW'(2);
        @(posedge clk); #1;
        start = 1'b0;
        guard = 0;
        while (!mac_in_valid && guard < 20) begin
            op_vld = op_req;
            op_a0 = m_a0[0]; op_a1 = m_a1[0]; op_b0 = m_b0[0]; op_b1 = m_b1[0];
            @(posedge clk); #1;
            guard++;
        end
        op_vld = 1'b0;
        check("midrst:reach_issue", int'(mac_in_valid), 1);
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        check("midrst:busy", int'(busy), 0);
        check("midrst:op_req", int'(op_req), 0);
        check("midrst:op_idx", int'(op_idx), 0);
        check("midrst:mac_in_valid", int'(mac_in_valid), 0);
        check("midrst:done", int'(done), 0);
        check("midrst:err", int'(err), 0);
        check("midrst:mac_a0", int'(mac_a0), 0);
        check("midrst:mac_b1", int'(mac_b1), 0);
        check("midrst:mac_acc00", int'(mac_acc00), 0);
        check("midrst:res11", int'(res11), 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        mac_out_valid = 1'b1;
        mac_y00 = 77; mac_y01 = 77; mac_y10 = 77; mac_y11 = 77;
        done_seen = 0;
        @(posedge clk); #1;
        mac_out_valid = 1'b0;
        check("late:err", int'(err), 1);
        check("late:res00", int'(res00), 0);
        check("late:mac_acc00", int'(mac_acc00), 0);
        check("late:busy", int'(busy), 0);
        for (int c = 0; c < 4; c++) begin
            if (done) done_seen++;
            @(posedge clk); #1;
        end
        check("late:no_done", done_seen, 0);

        m_a0[0] = 8'sd2;
        m_a1[0] = -8'sd3;
        m_b0[0] = 8'sd4;
        m_b1[0] = 8'sd5;
        run_job("post_rst_k1", 1, 0, 1, 1'b0, 8, 10, -12, -15, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gemm2x2_seq_ctrl.md
GEMM2X2_SEQ_CTRL -- requirements
Module: gemm2x2_seq_ctrl

Interface
REQ-001 Parameter: KW, default 8, width of the K-length count and slice index.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous and active-low.
REQ-004 start  input  1  request one 2x2 GEMM of k_len K-slices; sampled only in IDLE.
REQ-005 k_len  input  KW  number of K-slices; sampled with start.
REQ-006 busy  output  1  high whenever state is not IDLE.
REQ-007 done  output  1  one-cycle pulse when results are final.
REQ-008 op_req  output  1  operand-fetch request for slice op_idx.
REQ-009 op_idx  output  KW  K-slice index being fetched.
REQ-010 op_vld  input  1  operand-fetch response; completes the fetch in the cycle op_req and op_vld are both high.
REQ-011 op_a0, op_a1, op_b0, op_b1  input  8 each, signed  slice k: A[0][k], A[1][k], B[k][0], B[k][1].
REQ-012 mac_in_valid  output  1  issue strobe to the 2x2 MAC array.
REQ-013 mac_a0, mac_a1, mac_b0, mac_b1  output  8 each, signed  registered slice operands.
REQ-014 mac_acc00, mac_acc01, mac_acc10, mac_acc11  output  32 each, signed  running partial sums.
REQ-015 mac_out_valid  input  1  MAC result strobe; latency from mac_in_valid is arbitrary (>=1 cycle).
REQ-016 mac_y00, mac_y01, mac_y10, mac_y11  input  32 each, signed  MAC results.
REQ-017 res00, res01, res10, res11  output  32 each, signed  final C tile; held until the next accepted start.
REQ-018 err  output  1  sticky protocol error; cleared by reset or by an accepted start.

Function
REQ-019 FSM states SHALL be IDLE, FETCH, ISSUE, WAIT and DONE.
REQ-020 IDLE with start=1 SHALL: latch k_len; clear k_cnt, all partials, res* and err. If k_len=0, go to DONE; otherwise go to FETCH.
REQ-021 start SHALL be ignored in every state except IDLE.
REQ-022 FETCH: op_req=1 and op_idx=k_cnt, both held stable until op_vld.
REQ-023 FETCH, on op_vld=1: register op_a*/op_b* into mac_a*/mac_b*; the next state SHALL be ISSUE.
REQ-024 ISSUE: mac_in_valid=1 for exactly one cycle, with mac_acc* equal to the current partials; the next state SHALL be WAIT.
REQ-025 WAIT, on mac_out_valid=1: partials <= mac_y*; k_cnt increments.
REQ-026 After the WAIT update of REQ-025, the next state SHALL be DONE if the incremented k_cnt equals k_len, else FETCH.
REQ-027 DONE: res* = partials; done=1 for one cycle; the next state SHALL be IDLE.
REQ-028 mac_out_valid while not in WAIT SHALL be ignored for data and SHALL set err.
REQ-029 mac_acc* SHALL always reflect the partial-sum registers; no arithmetic is performed in this block.
REQ-030 Minimum latency, start to done, SHALL be 1 + k_len*(3 + L_mac - 1) + 1 cycles with zero op_vld wait, where L_mac is the MAC latency; each cycle of op_vld or MAC delay adds exactly one cycle.
REQ-031 k_len = 2^KW-1 SHALL complete without k_cnt wrap.

Reset
REQ-032 Asynchronous assertion of rst_n=0 SHALL force IDLE, with busy, done, op_req, mac_in_valid and err = 0 and op_idx = 0.
REQ-033 The same reset SHALL set mac_a*, mac_b*, mac_acc*, res* and k_cnt to 0.
REQ-034 Reset mid-operation SHALL abandon the job; no done pulse is produced.
REQ-035 A MAC result arriving after reset SHALL set err only; results SHALL NOT be corrupted.

Verification
REQ-036 K=2 case: A=[[1,2],[3,4]], B=[[5,6],[7,8]], k_len=2, op_vld immediate -> one done pulse; res = {19,22;43,50}; intermediate mac_acc = {5,6;15,18}.
REQ-037 k_len=0 -> done two cycles after start; res all 0; op_req and mac_in_valid never asserted.
REQ-038 K=2 case with op_vld delayed 3 cycles per slice and MAC latency 4 -> op_idx stable during each stall; same res {19,22;43,50}; latency per REQ-030.
REQ-039 Second start pulsed while busy -> ignored; exactly one done; res unchanged from first job.
REQ-040 rst_n pulsed low during WAIT of slice 0 -> all outputs 0 immediately; a late mac_out_valid sets err; then a new K=1 job (a0=2, a1=-3, b0=4, b1=5) -> res {8,10;-12,-15}, err cleared.
